acc_sequencer: RTL and testbench
================================

// Module: acc_sequencer
// PURPOSE
//  Owns the accumulator (AC) and zero flag and sequences one ALU operation per request.
//  Accepts {opcode, operand} over a valid/ready handshake and drives the combinational ALU's CS, ACin and Rin.
//  Commits the ALU result back into AC. Sits directly upstream of the ALU and feeds all of its inputs.
//  Also sits downstream of it, consuming ACout; decode/control issue requests into this block.
// PARAMETERS
//  WIDTH      16  datapath width of AC, operand and ALU result
//  MUL_STALL  2   extra EXEC cycles held for MUL (opcode 4'b0111); 0 allowed
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  op_valid    in   1      request valid
//  op_ready    out  1      block can accept a request (high only in IDLE)
//  op_code     in   4      ALU opcode: NOP=0 ADD=1 SUB=2 NOT=3 AND=4 OR=5 XOR=6 MUL=7 SHR1=8 SHR2=9 MOV=A CLA=B
//  op_data     in   WIDTH  operand (R)
//  alu_cs      out  4      to ALU CS
//  alu_ac      out  WIDTH  to ALU ACin (always equals ac)
//  alu_r       out  WIDTH  to ALU Rin
//  alu_result  in   WIDTH  from ALU ACout
//  ac          out  WIDTH  committed accumulator
//  z_flag      out  1      1 when last committed result == 0
//  done        out  1      one-cycle pulse: operation retired
//  op_err      out  1      one-cycle pulse with done: illegal opcode
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): state=IDLE, ac=0, z_flag=0, alu_cs=0, alu_r=0, done=0, op_err=0, op_ready=1 after the edge.
//  - Reset wins over everything, including mid-EXEC; any in-flight operation is abandoned with no commit.
//  - FSM IDLE -> EXEC -> DONE -> IDLE.
//  - IDLE: op_ready=1, alu_cs=NOP. On op_valid&op_ready, capture op_code/op_data into holding regs and go to EXEC.
//  - EXEC: alu_cs=held opcode, alu_r=held operand; the ALU result is valid combinationally in the same cycle.
//    Non-MUL: one EXEC cycle. MUL: 1+MUL_STALL EXEC cycles, counted by a stall counter loaded at accept.
//    At the edge ending the last EXEC cycle: ac<=alu_result; z_flag<=(alu_result==0), computed locally, not taken from the ALU.
//  - DONE: done=1 for exactly one cycle, alu_cs=NOP, then IDLE.
//  - Latency: accept at edge k; ac updated at edge k+1 (MUL: k+1+MUL_STALL); done high in the following cycle.
//    Throughput: 1 op per 3 cycles (MUL: 3+MUL_STALL).
//  - op_valid outside IDLE is ignored; the requester must hold its request until it sees op_ready.
//  - Illegal opcodes 4'hC-4'hF: EXEC drives alu_cs=NOP; no write to ac or z_flag; op_err=1 together with done.
//  - NOP commits ac unchanged but refreshes z_flag. CLA yields ac=0, z_flag=1. MUL keeps the low WIDTH bits.
//  - SUB is ac-op_data, modulo 2^WIDTH (wraps).
//  - Holding registers are stable for the whole of EXEC; ALU outputs must not change mid-operation.
// CONFIGURATION
//  CARRY_FLAG_EN defined:
//    - Adds output c_flag (1 bit), reset 0, updated at commit.
//    - ADD: carry-out of the (WIDTH+1)-bit sum ac+op_data. SUB: borrow (ac<op_data, unsigned).
//    - All other legal ops clear it. Illegal ops leave it unchanged.
//  CARRY_FLAG_EN undefined: no c_flag port and no carry logic.
// TESTING
//  1 Reset: hold rst_n=0 two cycles -> ac=0, z_flag=0, alu_cs=0, op_ready=1, done=0.
//  2 ac=0, ADD op_data=5 accepted at edge k -> alu_cs=1 during EXEC; ac=5, z_flag=0 at k+1; done pulse in the k+2 cycle.
//    Then SUB 5 -> ac=0, z_flag=1.
//  3 ac=7, MUL op_data=3 with MUL_STALL=2 -> op_ready=0 for 4 cycles; ac=21 at k+3; done one cycle.
//    op_valid pulsed during EXEC is ignored.
//  4 ac=0x1234, op_code=4'hC -> ac stays 0x1234, z_flag unchanged, done=1 and op_err=1 in the same cycle.
//  5 Reset asserted mid-MUL EXEC -> after the edge ac=0, state IDLE, no done pulse.
//  6 CARRY_FLAG_EN: ac=0xFFFF, ADD 1 -> ac=0, z_flag=1, c_flag=1. Then SUB 1 -> ac=0xFFFF, c_flag=1.

Source files
------------

// File: rtl/acc_sequencer.sv
// Accumulator sequencer: owns AC/Z, issues one ALU op per accepted request, commits ACout back into AC.
// Latency: accept at edge k, commit at edge k+1 (MUL: k+1+MUL_STALL), done pulse in the cycle after commit.
// Backpressure: op_ready high only in IDLE; one op in flight, 3 cycles per op (MUL: 3+MUL_STALL).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   op_valid/op_ready       request handshake; op_code (4b) and op_data (WIDTH) captured on accept
//   alu_cs, alu_ac, alu_r   drive the combinational ALU (CS, ACin, Rin)
//   alu_result              ALU ACout, committed into ac at the end of EXEC
//   ac, z_flag              committed accumulator and zero flag
//   done, op_err            one-cycle retire pulse; op_err marks an illegal opcode
//   c_flag                  carry/borrow flag, present only when CARRY_FLAG_EN is defined
//
// Optional feature macro: CARRY_FLAG_EN (adds c_flag output and carry/borrow logic).

module acc_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MUL_STALL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic [3:0]       alu_cs,
    output logic [WIDTH-1:0] alu_ac,
    output logic [WIDTH-1:0] alu_r,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] ac,
    output logic             z_flag,
`ifdef CARRY_FLAG_EN
    output logic             c_flag,
`endif
    output logic             done,
    output logic             op_err
);

    // ALU opcodes this block cares about; everything above OP_CLA is illegal.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h7;
    localparam logic [3:0] OP_CLA = 4'hB;

    // Stall counter must hold MUL_STALL; keep at least one bit when MUL_STALL is 0.
    localparam int          CW         = (MUL_STALL > 0) ? $clog2(MUL_STALL + 1) : 1;
    localparam logic [CW-1:0] STALL_INIT = CW'(MUL_STALL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   stall_cnt;
    logic            hold_illegal;
    logic            op_legal;
    logic            res_zero;

    assign op_legal = (op_code <= OP_CLA);
    assign res_zero = (alu_result == '0);

    // The ALU always sees the committed accumulator.
    assign alu_ac = ac;

`ifdef CARRY_FLAG_EN
    logic [WIDTH:0] add_wide;
    logic           add_carry;
    logic           sub_borrow;
    logic           carry_next;

    // Carry/borrow are derived here from ac and the held operand, not from the ALU.
    // During EXEC alu_cs holds the opcode for legal ops and alu_r holds the operand.
    assign add_wide   = {1'b0, ac} + {1'b0, alu_r};
    assign add_carry  = add_wide[WIDTH];
    assign sub_borrow = (ac < alu_r);

    always_comb begin
        carry_next = 1'b0;
        if (alu_cs == OP_ADD) begin
            carry_next = add_carry;
        end else if (alu_cs == OP_SUB) begin
            carry_next = sub_borrow;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ac           <= '0;
            z_flag       <= 1'b0;
            alu_cs       <= OP_NOP;
            alu_r        <= '0;
            done         <= 1'b0;
            op_err       <= 1'b0;
            op_ready     <= 1'b1;
            stall_cnt    <= '0;
            hold_illegal <= 1'b0;
`ifdef CARRY_FLAG_EN
            c_flag       <= 1'b0;
`endif
        end else begin
            // Retire pulses last exactly one cycle.
            done   <= 1'b0;
            op_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        op_ready     <= 1'b0;
                        alu_r        <= op_data;
                        hold_illegal <= !op_legal;
                        // Illegal opcodes run as NOP on the ALU so nothing spurious is driven.
                        alu_cs       <= op_legal ? op_code : OP_NOP;
                        stall_cnt    <= (op_code == OP_MUL) ? STALL_INIT : '0;
                        state        <= EXEC;
                    end
                end

                EXEC: begin
                    if (stall_cnt != '0) begin
                        stall_cnt <= stall_cnt - 1'b1;
                    end else begin
                        if (!hold_illegal) begin
                            ac     <= alu_result;
                            z_flag <= res_zero;
`ifdef CARRY_FLAG_EN
                            c_flag <= carry_next;
`endif
                        end
                        done   <= 1'b1;
                        op_err <= hold_illegal;
                        alu_cs <= OP_NOP;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    op_ready <= 1'b1;
                    alu_cs   <= OP_NOP;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: directed scenarios plus randomized ops checked against a transaction-level model.
// A behavioural ALU closes the loop combinationally on alu_cs/alu_ac/alu_r.
// Inputs change and outputs are sampled on the falling edge.

module tb_acc_sequencer;

    localparam int W  = 16;
    localparam int MS = 2;

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [W-1:0]  op_data;
    logic [3:0]    alu_cs;
    logic [W-1:0]  alu_ac;
    logic [W-1:0]  alu_r;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  ac;
    logic          z_flag;
    logic          done;
    logic          op_err;
`ifdef CARRY_FLAG_EN
    logic          c_flag;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model state.
    logic [W-1:0] m_ac;
    logic         m_z;
    logic         m_c;

    acc_sequencer #(.WIDTH(W), .MUL_STALL(MS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_data    (op_data),
        .alu_cs     (alu_cs),
        .alu_ac     (alu_ac),
        .alu_r      (alu_r),
        .alu_result (alu_result),
        .ac         (ac),
        .z_flag     (z_flag),
`ifdef CARRY_FLAG_EN
        .c_flag     (c_flag),
`endif
        .done       (done),
        .op_err     (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, plain arithmetic on integers.
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] r);
        longint unsigned ai, ri, m;
        ai = longint'(a);
        ri = longint'(r);
        m  = longint'(1) << W;
        case (op)
            4'h1:    return W'((ai + ri) % m);
            4'h2:    return W'((ai + m - ri) % m);
            4'h3:    return W'(m - 1 - ai);
            4'h4:    return a & r;
            4'h5:    return a | r;
            4'h6:    return a ^ r;
            4'h7:    return W'((ai * ri) % m);
            4'h8:    return W'(ai / 2);
            4'h9:    return W'(ai / 4);
            4'hA:    return r;
            4'hB:    return '0;
            default: return a;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_cs, alu_ac, alu_r);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it through EXEC and DONE, checking every cycle.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] d, input bit noise);
        int  n;
        int  exec_cycles;
        bit  legal;
        logic [W-1:0] nac;
        n = 0;
        while (op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(op_ready), 1);
        op_valid = 1'b1;
        op_code  = op;
        op_data  = d;
        @(negedge clk);
        legal       = (int'(op) <= 11);
        exec_cycles = (op == 4'h7) ? 1 + MS : 1;
        for (int i = 0; i < exec_cycles; i++) begin
            if (noise) begin
                op_valid = 1'($urandom_range(0, 1));
                op_code  = 4'($urandom);
                op_data  = W'($urandom);
            end else begin
                op_valid = 1'b0;
            end
            check("exec_ready", 32'(op_ready), 0);
            check("exec_done", 32'(done), 0);
            check("exec_cs", 32'(alu_cs), legal ? 32'(op) : 0);
            check("exec_r", 32'(alu_r), 32'(d));
            check("exec_ac_unchanged", 32'(ac), 32'(m_ac));
            @(negedge clk);
        end
        op_valid = 1'b0;
        if (legal) begin
            nac = alu_fn(op, m_ac, d);
            if (op == 4'h1)      m_c = (int'(m_ac) + int'(d)) >= (1 << W);
            else if (op == 4'h2) m_c = (int'(m_ac) < int'(d));
            else                 m_c = 1'b0;
            m_ac = nac;
            m_z  = (int'(nac) == 0);
        end
        check("done_pulse", 32'(done), 1);
        check("done_err", 32'(op_err), legal ? 0 : 1);
        check("done_ac", 32'(ac), 32'(m_ac));
        check("done_alu_ac", 32'(alu_ac), 32'(m_ac));
        check("done_z", 32'(z_flag), 32'(m_z));
        check("done_cs", 32'(alu_cs), 0);
        check("done_ready", 32'(op_ready), 0);
`ifdef CARRY_FLAG_EN
        check("done_c", 32'(c_flag), 32'(m_c));
`endif
        @(negedge clk);
        check("idle_done_low", 32'(done), 0);
        check("idle_err_low", 32'(op_err), 0);
        check("idle_ready", 32'(op_ready), 1);
        check("idle_ac", 32'(ac), 32'(m_ac));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] rd;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = 4'h0;
        op_data  = '0;
        m_ac     = '0;
        m_z      = 1'b0;
        m_c      = 1'b0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_ac", 32'(ac), 0);
        check("rst_z", 32'(z_flag), 0);
        check("rst_cs", 32'(alu_cs), 0);
        check("rst_r", 32'(alu_r), 0);
        check("rst_ready", 32'(op_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(op_err), 0);
`ifdef CARRY_FLAG_EN
        check("rst_c", 32'(c_flag), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ADD then SUB back to zero.
        do_op(4'h1, 16'd5, 1'b0);
        do_op(4'h2, 16'd5, 1'b0);
        check("sub_to_zero_z", 32'(z_flag), 1);

        // MUL with stall; request lines toggled during EXEC must be ignored.
        do_op(4'hA, 16'd7, 1'b0);
        do_op(4'h7, 16'd3, 1'b1);
        check("mul_result", 32'(ac), 21);

        // Illegal opcode leaves ac and z untouched.
        do_op(4'hA, 16'h1234, 1'b0);
        do_op(4'hC, 16'h00FF, 1'b1);
        check("illegal_keeps_ac", 32'(ac), 32'h1234);
        do_op(4'hF, 16'h0001, 1'b0);

        // NOP refreshes z, CLA clears.
        do_op(4'h0, 16'hBEEF, 1'b0);
        do_op(4'hB, 16'hBEEF, 1'b0);
        check("cla_z", 32'(z_flag), 1);

        // Randomized traffic, biased toward tiny operands to hit zero/wrap cases.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            rd  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            do_op(rop, rd, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a MUL: no commit, no done.
        do_op(4'hA, 16'h0009, 1'b0);
        op_valid = 1'b1;
        op_code  = 4'h7;
        op_data  = 16'd3;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        check("midmul_ac_held", 32'(ac), 9);
        rst_n = 1'b0;
        @(negedge clk);
        m_ac = '0;
        m_z  = 1'b0;
        m_c  = 1'b0;
        check("midrst_ac", 32'(ac), 0);
        check("midrst_z", 32'(z_flag), 0);
        check("midrst_ready", 32'(op_ready), 1);
        check("midrst_done", 32'(done), 0);
        check("midrst_cs", 32'(alu_cs), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_done", 32'(done), 0);
        check("postrst_ready", 32'(op_ready), 1);
        check("postrst_ac", 32'(ac), 0);

        // Wrap cases for ADD and SUB.
        do_op(4'hA, 16'hFFFF, 1'b0);
        do_op(4'h1, 16'h0001, 1'b0);
        check("add_wrap_ac", 32'(ac), 0);
        check("add_wrap_z", 32'(z_flag), 1);
        do_op(4'h2, 16'h0001, 1'b0);
        check("sub_wrap_ac", 32'(ac), 32'hFFFF);
`ifdef CARRY_FLAG_EN
        check("sub_wrap_c", 32'(c_flag), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
